// File: rtl/circular_right_shift_sequential.sv
// ----------------------------------------------------------------------------
// circular_right_shift_sequential
//
// Rotates an N-bit word by S positions, one bit per clock, behind a
// request/response handshake. The block takes one word at a time.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge,
// and the consumer may raise or lower ready at any time. up_rdy is high only
// in IDLE. down_vld is high only in DONE, and down_data is held stable there
// until down_rdy is seen.
//
// Timing: the accept edge is cycle 0. After it the block spends S cycles in
// SHIFT and reaches DONE in cycle S+1. Back-to-back requests are S+2 cycles
// apart, because DONE always returns to IDLE before a new word is accepted.
//
// Parameters:
//   N  data width (power of two, >= 2)
//   W  shift-amount width, $clog2(N)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   up_vld     request valid
//   up_rdy     block can accept a request (IDLE)
//   up_data    word to rotate
//   up_shift   rotate amount S, 0..N-1
//   up_dir     (CIRC_SHIFT_DIR_SEL_EN only) 0 = rotate right, 1 = rotate left
//   down_vld   result valid (DONE)
//   down_rdy   downstream accepts the result
//   down_data  rotated word (meaningful while down_vld is high)
//   dbg_state  current FSM state, for observation
//
// Build option: define CIRC_SHIFT_DIR_SEL_EN to add up_dir and left rotation.
// Without it the block rotates right only.
// ----------------------------------------------------------------------------
module circular_right_shift_sequential #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_vld,
    output logic         up_rdy,
    input  logic [N-1:0] up_data,
    input  logic [W-1:0] up_shift,
`ifdef CIRC_SHIFT_DIR_SEL_EN
    input  logic         up_dir,
`endif
    output logic         down_vld,
    input  logic         down_rdy,
    output logic [N-1:0] down_data,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   data_q,  data_d;
    logic [W-1:0]   cnt_q,   cnt_d;

`ifdef CIRC_SHIFT_DIR_SEL_EN
    logic           dir_q,   dir_d;
`endif

    // One-bit rotation of the data register.
    logic [N-1:0]   rot_one;

`ifdef CIRC_SHIFT_DIR_SEL_EN
    always_comb begin
        if (dir_q) begin
            rot_one = {data_q[N-2:0], data_q[N-1]};
        end else begin
            rot_one = {data_q[0], data_q[N-1:1]};
        end
    end
`else
    assign rot_one = {data_q[0], data_q[N-1:1]};
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef CIRC_SHIFT_DIR_SEL_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef CIRC_SHIFT_DIR_SEL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef CIRC_SHIFT_DIR_SEL_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                // up_rdy is high in IDLE, so up_vld alone means acceptance.
                if (up_vld) begin
                    data_d = up_data;
                    cnt_d  = up_shift;
`ifdef CIRC_SHIFT_DIR_SEL_EN
                    dir_d  = up_dir;
`endif
                    state_d = (up_shift == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = rot_one;
                cnt_d  = cnt_q - W'(1);
                // The last shift is the one that takes the counter from 1 to 0.
                if (cnt_q == W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (down_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        up_rdy    = (state_q == IDLE);
        down_vld  = (state_q == DONE);
        dbg_state = state_q;
    end

    assign down_data = data_q;

endmodule

// File: tb/tb_circular_right_shift_sequential.sv
module tb_circular_right_shift_sequential;

    localparam int N = 8;
    localparam int W = 3;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         up_vld = 1'b0;
    logic [N-1:0] up_data = '0;
    logic [W-1:0] up_shift = '0;
`ifdef CIRC_SHIFT_DIR_SEL_EN
    logic         up_dir = 1'b0;
`endif
    logic         down_rdy = 1'b0;
    logic         up_rdy;
    logic         down_vld;
    logic [N-1:0] down_data;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    circular_right_shift_sequential #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vld    (up_vld),
        .up_rdy    (up_rdy),
        .up_data   (up_data),
        .up_shift  (up_shift),
`ifdef CIRC_SHIFT_DIR_SEL_EN
        .up_dir    (up_dir),
`endif
        .down_vld  (down_vld),
        .down_rdy  (down_rdy),
        .down_data (down_data),
        .dbg_state (dbg_state)
    );

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Rotation computed directly from the amount, not bit by bit.
    function automatic logic [N-1:0] rot(input logic [N-1:0] x, input int s, input bit left);
        logic [2*N-1:0] dbl;
        dbl = {x, x};
        if (left) begin
            dbl = dbl << s;
            return dbl[2*N-1:N];
        end
        dbl = dbl >> s;
        return dbl[N-1:0];
    endfunction

    // Model state: busy flag, cycle index at which the result becomes valid,
    // and a flag meaning "reset seen, no word accepted since" (data must be 0).
    logic [N-1:0] exp_q[$];
    int  cyc       = 0;
    bit  m_busy    = 1'b0;
    int  m_vld_from = 0;
    bit  m_zero    = 1'b1;
    bit  cmp_en    = 1'b0;

    always @(posedge clk) begin
        bit dir_v;
`ifdef CIRC_SHIFT_DIR_SEL_EN
        dir_v = up_dir;
`else
        dir_v = 1'b0;
`endif
        if (rst) begin
            m_busy = 1'b0;
            m_zero = 1'b1;
            exp_q.delete();
        end else if (!m_busy) begin
            if (up_vld) begin
                exp_q.push_back(rot(up_data, int'(up_shift), dir_v));
                m_busy     = 1'b1;
                m_vld_from = cyc + 1 + int'(up_shift);
                m_zero     = 1'b0;
            end
        end else if (cyc >= m_vld_from && down_rdy) begin
            void'(exp_q.pop_front());
            m_busy = 1'b0;
        end
        cyc++;
    end

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_vld;
            exp_vld = m_busy && (cyc >= m_vld_from);
            check("up_rdy", 32'(up_rdy), 32'(!m_busy));
            check("down_vld", 32'(down_vld), 32'(exp_vld));
            if (exp_vld && exp_q.size() > 0) begin
                check("down_data", 32'(down_data), 32'(exp_q[0]));
            end else if (m_zero) begin
                check("down_data_rst", 32'(down_data), 32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic directed(input string tag, input logic [N-1:0] d, input int s,
                            input bit left, input logic [N-1:0] exp_d, input int exp_lat);
        int lat;
        @(negedge clk);
        up_vld   = 1'b1;
        up_data  = d;
        up_shift = W'(s);
`ifdef CIRC_SHIFT_DIR_SEL_EN
        up_dir   = left;
`else
        if (left) $display("note: left rotation needs CIRC_SHIFT_DIR_SEL_EN");
`endif
        down_rdy = 1'b1;
        @(negedge clk);
        up_vld = 1'b0;
        lat    = 1;
        while (!down_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(down_data), 32'(exp_d));
        @(negedge clk);
`ifdef CIRC_SHIFT_DIR_SEL_EN
        up_dir = 1'b0;
`endif
    endtask

    task automatic hold_test();
        int lat;
        @(negedge clk);
        up_vld   = 1'b1;
        up_data  = 8'b0011_1100;
        up_shift = 3'd2;
        down_rdy = 1'b0;
        @(negedge clk);
        up_vld = 1'b0;
        lat    = 1;
        while (!down_vld && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("hold_latency", 32'(lat), 32'(3));
        for (int i = 0; i < 5; i++) begin
            check("hold_vld", 32'(down_vld), 32'(1));
            check("hold_data", 32'(down_data), 32'(8'b0000_1111));
            check("hold_up_rdy", 32'(up_rdy), 32'(0));
            @(negedge clk);
        end
        down_rdy = 1'b1;
        @(negedge clk);
        check("hold_release_up_rdy", 32'(up_rdy), 32'(1));
        check("hold_release_vld", 32'(down_vld), 32'(0));
    endtask

    task automatic reset_midflight_test();
        @(negedge clk);
        up_vld   = 1'b1;
        up_data  = 8'hA5;
        up_shift = 3'd5;
        down_rdy = 1'b1;
        @(negedge clk);   // cycle 1
        up_vld = 1'b0;
        @(negedge clk);   // cycle 2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_vld", 32'(down_vld), 32'(0));
        check("rst_data", 32'(down_data), 32'(0));
        check("rst_up_rdy", 32'(up_rdy), 32'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_vld", 32'(down_vld), 32'(0));
        end
    endtask

    // ---------------- main ----------------
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("reset_up_rdy", 32'(up_rdy), 32'(1));
        check("reset_down_vld", 32'(down_vld), 32'(0));
        check("reset_down_data", 32'(down_data), 32'(0));
        rst = 1'b0;

        // Pin the model itself against hand-computed values.
        check("model_ror3", 32'(rot(8'b1011_0101, 3, 1'b0)), 32'(8'b1011_0110));
        check("model_rol3", 32'(rot(8'b1011_0101, 3, 1'b1)), 32'(8'b1010_1101));

        directed("s3",  8'b1011_0101, 3, 1'b0, 8'b1011_0110, 4);
        directed("s0",  8'b0101_1010, 0, 1'b0, 8'b0101_1010, 1);
        directed("s7",  8'b0000_0001, 7, 1'b0, 8'b0000_0010, 8);
        directed("s1",  8'b1000_0000, 1, 1'b0, 8'b0100_0000, 2);
`ifdef CIRC_SHIFT_DIR_SEL_EN
        directed("l3",  8'b1011_0101, 3, 1'b1, 8'b1010_1101, 4);
`endif
        hold_test();
        reset_midflight_test();

        // Random traffic, including inputs wiggling while busy and rare resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 63) == 0);
            up_vld   = $urandom_range(0, 1) == 1;
            up_data  = N'($urandom);
            up_shift = W'($urandom_range(0, N - 1));
`ifdef CIRC_SHIFT_DIR_SEL_EN
            up_dir   = $urandom_range(0, 1) == 1;
`endif
            down_rdy = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        rst      = 1'b0;
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_idle", 32'(up_rdy), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/circular_right_shift_sequential.md
CIRCULAR_RIGHT_SHIFT_SEQUENTIAL -- requirements
Module: circular_right_shift_sequential

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits; legal values are powers of two, N >= 2.
REQ-002 SHALL have parameter W, default $clog2(N), width of the shift-amount field.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port up_vld, input, 1 bit, upstream request valid.
REQ-006 SHALL have port up_rdy, output, 1 bit, block can accept a request.
REQ-007 SHALL have port up_data, input, N bits, word to rotate.
REQ-008 SHALL have port up_shift, input, W bits, unsigned rotate amount S, 0..N-1.
REQ-009 SHALL have port down_vld, output, 1 bit, result valid.
REQ-010 SHALL have port down_rdy, input, 1 bit, downstream accepts the result.
REQ-011 SHALL have port down_data, output, N bits, rotated word.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL drive up_rdy high only in IDLE and down_vld high only in DONE.
REQ-014 SHALL accept a request on a rising edge where up_vld and up_rdy are both high; that cycle is cycle 0.
REQ-015 SHALL, on acceptance, load up_data into the data register and up_shift into a down-counter.
REQ-016 SHALL, on acceptance with S=0, go to DONE; with S>0, go to SHIFT.
REQ-017 SHALL, in each SHIFT cycle, rotate the data register right by exactly one bit: bit 0 moves to bit N-1, all other bits move one position down.
REQ-018 SHALL decrement the counter in each SHIFT cycle and go to DONE on the edge where the counter goes from 1 to 0.
REQ-019 SHALL assert down_vld first in cycle S+1: cycle 1 for S=0, cycle 4 for S=3.
REQ-020 SHALL, in DONE, hold down_vld and down_data stable until down_rdy is high, then return to IDLE on that edge.
REQ-021 SHALL keep up_rdy low in DONE even when down_rdy is high; there is no same-edge accept, so the minimum request spacing is S+2 cycles.
REQ-022 SHALL drive down_data continuously from the data register; its value is meaningful only while down_vld is high.
REQ-023 SHALL ignore up_data, up_shift and up_vld outside IDLE.

Reset
REQ-024 SHALL, with rst high on a rising edge, force state to IDLE, the data register to 0 and the counter to 0, overriding all other inputs.
REQ-025 SHALL, on reset in SHIFT or DONE, discard the in-flight word with no down_vld pulse; up_rdy is high in the first cycle after the reset edge.
REQ-026 SHALL hold outputs during and after reset at: up_rdy=1 (state IDLE), down_vld=0, down_data=0.

Configuration
REQ-027 SHALL, with CIRC_SHIFT_DIR_SEL_EN defined, add input port up_dir, 1 bit, captured on acceptance: 0 selects right rotation, 1 selects left rotation (bit N-1 moves to bit 0 each SHIFT cycle); latency is unchanged.
REQ-028 SHALL, without CIRC_SHIFT_DIR_SEL_EN, omit up_dir and rotate right only; behaviour is otherwise identical.

Verification
REQ-029 SHALL cover: up_data=10110101, S=3, down_rdy=1 -> down_vld first high in cycle 4, down_data=10110110.
REQ-030 SHALL cover: up_data=01011010, S=0 -> down_vld in cycle 1, down_data=01011010.
REQ-031 SHALL cover: up_data=00000001, S=7 -> down_data=00000010 in cycle 8.
REQ-032 SHALL cover: down_rdy low for 5 cycles in DONE -> down_vld and down_data held, up_rdy=0 throughout; IDLE on the edge after down_rdy rises.
REQ-033 SHALL cover: rst pulsed in cycle 2 of an S=5 request -> no down_vld, down_data=0, up_rdy=1 on the next cycle.
REQ-034 SHALL cover, with CIRC_SHIFT_DIR_SEL_EN and up_dir=1: up_data=10110101, S=3 -> down_data=10101101 in cycle 4.
